display_scan_controller: RTL and testbench

Time-multiplexed scan controller for the digital clock's multi-digit common-anode seven-segment display. Each frame it snapshots the BCD digit vector from the timekeeping and mode logic. It drives one digit at a time through the shared BCD-to-segment decoder, with a blanking guard interval between digits to prevent ghosting. It sits between the clock/alarm/stopwatch datapath and the board display pins.

---
 rtl/display_scan_controller_pkg.sv | 16 +
 rtl/display_scan_controller_if.sv | 25 ++
 rtl/display_scan_controller_dec.sv | 24 ++
 rtl/display_scan_controller.sv | 189 ++++++++++++++++++
 tb/tb_display_scan_controller.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/display_scan_controller_pkg.sv
// Shared types and constants for the seven-segment display scan controller.
package display_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_GUARD = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_t;

    // Active-low segment vector, bit order {g,f,e,d,c,b,a}
    typedef logic [6:0] seg_n_t;

    localparam seg_n_t     SEG_BLANK = 7'h7F;
    localparam logic [3:0] BCD_BLANK = 4'hF;

endpackage

// File: rtl/display_scan_controller_if.sv
// Datapath-to-display bundle: digit snapshot inputs on one side, display pin drives on the other.
interface display_scan_controller_if
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 6
);
    logic                    enable;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [NUM_DIGITS-1:0]   anodes_n;
    seg_n_t                  segments;
    logic                    dp_n;
    logic                    frame_start;

    modport master (
        output enable, digits_in, dp_in, blink_mask,
        input  anodes_n, segments, dp_n, frame_start
    );

    modport slave (
        input  enable, digits_in, dp_in, blink_mask,
        output anodes_n, segments, dp_n, frame_start
    );
endinterface

// File: rtl/display_scan_controller_dec.sv
// Combinational BCD to seven-segment decoder, active-low outputs; codes 10..15 are dark.
module display_scan_controller_dec
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output seg_n_t     seg
);
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/display_scan_controller.sv
// Frame-snapshot digit scanner with guard blanking between anodes.
// Optional per-digit blinking is built when DISPLAY_BLINK_EN is defined.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 6,
    parameter int DRIVE_CYCLES = 50000,
    parameter int GUARD_CYCLES = 500,
    parameter int BLINK_FRAMES = 60
) (
    input logic                      clk,
    input logic                      reset,
    display_scan_controller_if.slave bus
);
    // state | meaning
    // OFF   | display dark, idx 0, waiting for enable
    // GUARD | all anodes off, segments/dp already show digit idx
    // DRIVE | anode idx active

    localparam int CNT_MAX = (DRIVE_CYCLES > GUARD_CYCLES) ? DRIVE_CYCLES : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(DRIVE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t             state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    capture;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [3:0]              nibble;
    seg_n_t                  seg_dec;
    logic                    hide;

    logic [NUM_DIGITS-1:0]   anodes_d, anodes_q;
    seg_n_t                  segments_d, segments_q;
    logic                    dp_n_d, dp_n_q;
    logic                    frame_start_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (!bus.enable) begin
            state_d = ST_OFF;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_GUARD;
                    idx_d   = '0;
                    cnt_d   = GUARD_LOAD;
                    capture = 1'b1;
                end
                ST_GUARD: begin
                    if (cnt_q == '0) begin
                        state_d = ST_DRIVE;
                        cnt_d   = DRIVE_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == '0) begin
                        state_d = ST_GUARD;
                        cnt_d   = GUARD_LOAD;
                        if (idx_q == IDX_LAST) begin
                            idx_d   = '0;
                            capture = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Decode from the next-cycle snapshot so outputs line up with state/idx in the same cycle.
    assign digits_d = capture ? bus.digits_in : digits_q;
    assign dp_d     = capture ? bus.dp_in     : dp_q;
    assign nibble   = digits_d[{idx_d, 2'b00} +: 4];

    display_scan_controller_dec u_dec (
        .bcd (nibble),
        .seg (seg_dec)
    );

`ifdef DISPLAY_BLINK_EN
    localparam int BF_W = $clog2(BLINK_FRAMES) + 1;
    localparam logic [BF_W-1:0] BLINK_LOAD = BF_W'(BLINK_FRAMES - 1);

    logic [BF_W-1:0]       bcnt_q, bcnt_d;
    logic                  phase_q, phase_d;
    logic [NUM_DIGITS-1:0] mask_q, mask_d;

    // phase 1 = hidden; the first frame after OFF does not count toward the period
    always_comb begin
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        mask_d  = capture ? bus.blink_mask : mask_q;
        if (state_d == ST_OFF) begin
            bcnt_d  = BLINK_LOAD;
            phase_d = 1'b0;
        end else if (capture && (state_q != ST_OFF)) begin
            if (bcnt_q == '0) begin
                bcnt_d  = BLINK_LOAD;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q - 1'b1;
            end
        end
    end

    assign hide = phase_d & mask_d[idx_d];

    always_ff @(posedge clk) begin
        if (reset) begin
            bcnt_q  <= BLINK_LOAD;
            phase_q <= 1'b0;
            mask_q  <= '0;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            mask_q  <= mask_d;
        end
    end
`else
    localparam int UNUSED_BLINK_FRAMES = BLINK_FRAMES;
    logic unused_blink;
    assign unused_blink = ^bus.blink_mask;
    assign hide         = 1'b0;
`endif

    always_comb begin
        anodes_d   = '1;
        segments_d = SEG_BLANK;
        dp_n_d     = 1'b1;
        if (state_d == ST_DRIVE) begin
            anodes_d[idx_d] = 1'b0;
        end
        if ((state_d != ST_OFF) && !hide) begin
            segments_d = seg_dec;
            dp_n_d     = ~dp_d[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_OFF;
            idx_q         <= '0;
            cnt_q         <= '0;
            digits_q      <= {NUM_DIGITS{BCD_BLANK}};
            dp_q          <= '0;
            anodes_q      <= '1;
            segments_q    <= SEG_BLANK;
            dp_n_q        <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            digits_q      <= digits_d;
            dp_q          <= dp_d;
            anodes_q      <= anodes_d;
            segments_q    <= segments_d;
            dp_n_q        <= dp_n_d;
            frame_start_q <= capture;
        end
    end

    assign bus.anodes_n    = anodes_q;
    assign bus.segments    = segments_q;
    assign bus.dp_n        = dp_n_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller: 4 digits, 8 drive, 2 guard, 2 blink frames.
module tb_display_scan_controller;
    import display_pkg::*;

    localparam int ND    = 4;
    localparam int DC    = 8;
    localparam int GC    = 2;
    localparam int BF    = 2;
    localparam int SLOT  = GC + DC;
    localparam int FRAME = ND * SLOT;

    // Expected segment patterns packed {digit3, digit2, digit1, digit0}
    localparam logic [27:0] SEGS_1234   = {7'h79, 7'h24, 7'h30, 7'h19};
    localparam logic [27:0] SEGS_5678   = {7'h12, 7'h02, 7'h78, 7'h00};
    localparam logic [27:0] SEGS_F0F9   = {7'h7F, 7'h40, 7'h7F, 7'h10};
    localparam logic [27:0] SEGS_12__   = {7'h79, 7'h24, 7'h7F, 7'h7F};

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    display_scan_controller_if #(.NUM_DIGITS(ND)) bus ();

    display_scan_controller #(
        .NUM_DIGITS   (ND),
        .DRIVE_CYCLES (DC),
        .GUARD_CYCLES (GC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_dark(input string tag);
        check({tag, " anodes"}, 32'(bus.anodes_n), 32'hF);
        check({tag, " segs"}, 32'(bus.segments), 32'h7F);
        check({tag, " dp_n"}, 32'(bus.dp_n), 32'h1);
        check({tag, " frame_start"}, 32'(bus.frame_start), 32'h0);
    endtask

    // Starts at a frame_start cycle; checks ncyc cycles, optionally changing inputs at chg_t.
    task automatic run_frame(input string tag, input logic [27:0] segs, input logic [3:0] dpn,
                             input int ncyc, input int chg_t,
                             input logic [15:0] chg_digits, input logic [3:0] chg_dp);
        int         k;
        int         p;
        logic [3:0] an_exp;
        for (int t = 0; t < ncyc; t++) begin
            k = t / SLOT;
            p = t % SLOT;
            an_exp = (p < GC) ? 4'hF : ~(4'b0001 << k);
            check($sformatf("%s t=%0d anodes", tag, t), 32'(bus.anodes_n), 32'(an_exp));
            check($sformatf("%s t=%0d segs", tag, t), 32'(bus.segments), 32'(segs[k*7 +: 7]));
            check($sformatf("%s t=%0d dp_n", tag, t), 32'(bus.dp_n), 32'(dpn[k]));
            check($sformatf("%s t=%0d frame_start", tag, t), 32'(bus.frame_start),
                  (t == 0) ? 32'h1 : 32'h0);
            if (t == chg_t) begin
                bus.digits_in = chg_digits;
                bus.dp_in     = chg_dp;
            end
            tick();
        end
    endtask

    initial begin
        logic [27:0] blink_segs;

        reset          = 1'b1;
        bus.enable     = 1'b0;
        bus.digits_in  = 16'h0000;
        bus.dp_in      = 4'b0000;
        bus.blink_mask = 4'b0000;
        tick();
        tick();
        check_dark("reset");
        tick();
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tick();
            check_dark($sformatf("idle%0d", i));
        end

        // Normal scan of 1234, two back-to-back frames
        bus.digits_in = 16'h1234;
        bus.enable    = 1'b1;
        tick();
        run_frame("f1234a", SEGS_1234, 4'hF, FRAME, -1, 16'h0, 4'h0);
        run_frame("f1234b", SEGS_1234, 4'hF, FRAME, -1, 16'h0, 4'h0);

        // Mid-frame change must not tear
        run_frame("tear_old", SEGS_1234, 4'hF, FRAME, 15, 16'h5678, 4'b0000);
        run_frame("tear_new", SEGS_5678, 4'hF, FRAME, 30, 16'hF0F9, 4'b0100);

        // Blank codes and decimal point
        run_frame("blank_dp", SEGS_F0F9, 4'b1011, FRAME, -1, 16'h0, 4'h0);

        // Enable dropped during DRIVE of digit 2, re-raised 5 cycles later
        run_frame("pre_drop", SEGS_F0F9, 4'b1011, 26, -1, 16'h0, 4'h0);
        bus.enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_dark($sformatf("dropped%0d", i));
        end
        bus.enable = 1'b1;
        tick();
        run_frame("restart", SEGS_F0F9, 4'b1011, FRAME, -1, 16'h0, 4'h0);

        // Same with a reset pulse
        run_frame("pre_rst", SEGS_F0F9, 4'b1011, 26, -1, 16'h0, 4'h0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_dark($sformatf("midreset%0d", i));
        end
        reset = 1'b0;
        tick();
        run_frame("post_rst", SEGS_F0F9, 4'b1011, FRAME, -1, 16'h0, 4'h0);

        // Blink: digits 0-1 flash, frames counted from the enable rise
        bus.enable = 1'b0;
        tick();
        tick();
        check_dark("pre_blink");
        bus.digits_in  = 16'h1234;
        bus.dp_in      = 4'b0000;
        bus.blink_mask = 4'b0011;
        bus.enable     = 1'b1;
        tick();
        for (int f = 0; f < 6; f++) begin
            blink_segs = SEGS_1234;
`ifdef DISPLAY_BLINK_EN
            if (f == 2 || f == 3) begin
                blink_segs = SEGS_12__;
            end
`endif
            run_frame($sformatf("blink_f%0d", f), blink_segs, 4'hF, FRAME, -1, 16'h0, 4'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
